// File: rtl/ascon_serial_host.sv
// Parallel-to-serial host for the bit-serial Ascon core: loads key/nonce/AD/data, pulses start, captures out/tag.
// Latency: 128 load + 1 start + W wait (incl. trigger) + 127 capture cycles, then a one-cycle response strobe.
// Backpressure: cmd_ready is high only when idle; no response-side backpressure, rsp_valid is a single-cycle strobe.
module ascon_serial_host #(
  parameter int AD_W    = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_decrypt,
  input  logic [127:0]      cmd_key,
  input  logic [127:0]      cmd_nonce,
  input  logic [AD_W-1:0]   cmd_ad,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_timeout,
  output logic [DATA_W-1:0] rsp_data,
  output logic [127:0]      rsp_tag,
  output logic              key_so,
  output logic              nonce_so,
  output logic              ad_so,
  output logic              data_so,
  output logic              start_so,
  output logic              decrypt_so,
  input  logic              out_si,
  input  logic              tag_si,
  input  logic              ready_si
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] DATA_LEN  = 16'(DATA_W);
  localparam logic [15:0] BIT_LAST  = 16'd127;

  state_t              state, state_d;
  logic [127:0]        key_sr, nonce_sr, tag_sr, tag_nxt;
  logic [AD_W-1:0]     ad_sr;
  logic [DATA_W-1:0]   data_sr, out_sr, out_nxt;
  logic [15:0]         cnt;
  logic                ready_q;
  logic                accept, trigger, wait_expired, last_bit;

  assign cmd_ready    = (state == S_IDLE);
  assign rsp_valid    = (state == S_DONE);
  assign accept       = cmd_valid & cmd_ready;
  // Only a fresh rising edge of ready counts; a level left over from a previous job is ignored.
  assign trigger      = ready_si & ~ready_q;
  assign wait_expired = (cnt == WAIT_LAST);
  assign last_bit     = (cnt == BIT_LAST);
  // Tag always shifts; output data stops shifting once DATA_W bits are in, later bits are discarded.
  assign tag_nxt      = {tag_sr[126:0], tag_si};
  assign out_nxt      = (cnt < DATA_LEN) ? ((out_sr << 1) | DATA_W'(out_si)) : out_sr;

  // Delayed copy of ready for edge detection, tracked in every state.
  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= ready_si;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; trigger wins over timeout in the same cycle.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (accept) state_d = S_LOAD;
      S_LOAD:    if (last_bit) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (trigger)           state_d = S_CAPTURE;
        else if (wait_expired) state_d = S_DONE;
      end
      S_CAPTURE: if (last_bit) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Shift registers, serial pin registers, counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sr      <= '0;
      nonce_sr    <= '0;
      ad_sr       <= '0;
      data_sr     <= '0;
      tag_sr      <= '0;
      out_sr      <= '0;
      cnt         <= '0;
      key_so      <= 1'b0;
      nonce_so    <= 1'b0;
      ad_so       <= 1'b0;
      data_so     <= 1'b0;
      start_so    <= 1'b0;
      decrypt_so  <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Present bit 0 on the pins right away so LOAD cycle i shows bit 127-i.
            key_so     <= cmd_key[127];
            nonce_so   <= cmd_nonce[127];
            ad_so      <= cmd_ad[AD_W-1];
            data_so    <= cmd_data[DATA_W-1];
            key_sr     <= cmd_key << 1;
            nonce_sr   <= cmd_nonce << 1;
            ad_sr      <= cmd_ad << 1;
            data_sr    <= cmd_data << 1;
            decrypt_so <= cmd_decrypt;
            cnt        <= '0;
          end
        end
        S_LOAD: begin
          if (last_bit) begin
            key_so   <= 1'b0;
            nonce_so <= 1'b0;
            ad_so    <= 1'b0;
            data_so  <= 1'b0;
            start_so <= 1'b1;
          end else begin
            // Zero fill makes AD/data lines idle low once their bits run out.
            key_so   <= key_sr[127];
            nonce_so <= nonce_sr[127];
            ad_so    <= ad_sr[AD_W-1];
            data_so  <= data_sr[DATA_W-1];
            key_sr   <= key_sr << 1;
            nonce_sr <= nonce_sr << 1;
            ad_sr    <= ad_sr << 1;
            data_sr  <= data_sr << 1;
            cnt      <= cnt + 16'd1;
          end
        end
        S_START: begin
          start_so <= 1'b0;
          cnt      <= '0;
        end
        S_WAIT: begin
          if (trigger) begin
            // Trigger cycle carries bit 0 of both output streams.
            tag_sr <= {127'd0, tag_si};
            out_sr <= DATA_W'(out_si);
            cnt    <= 16'd1;
          end else if (wait_expired) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
            rsp_tag     <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CAPTURE: begin
          tag_sr <= tag_nxt;
          out_sr <= out_nxt;
          cnt    <= cnt + 16'd1;
          if (last_bit) begin
            rsp_tag     <= tag_nxt;
            rsp_data    <= out_nxt;
            rsp_timeout <= 1'b0;
          end
        end
        S_DONE: begin
          decrypt_so <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serial_host.sv
// Directed bench for ascon_serial_host: reset, load stream, capture, timeout, held-ready and back-to-back.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// A second instance with TIMEOUT=16 and ready tied low covers the abort path.
module tb_ascon_serial_host;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_valid_t, cmd_decrypt;
  logic [127:0] cmd_key, cmd_nonce;
  logic [63:0]  cmd_ad, cmd_data;
  logic         out_si, tag_si, ready_si;

  logic         cmd_ready, rsp_valid, rsp_timeout;
  logic [63:0]  rsp_data;
  logic [127:0] rsp_tag;
  logic         key_so, nonce_so, ad_so, data_so, start_so, decrypt_so;

  logic         cmd_ready_t, rsp_valid_t, rsp_timeout_t;
  logic [63:0]  rsp_data_t;
  logic [127:0] rsp_tag_t;
  logic         key_so_t, nonce_so_t, ad_so_t, data_so_t, start_so_t, decrypt_so_t;

  int checks = 0;
  int errors = 0;
  int vcount;

  always #5 clk = ~clk;

  ascon_serial_host #(.AD_W(64), .DATA_W(64), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_decrypt(cmd_decrypt), .cmd_key(cmd_key), .cmd_nonce(cmd_nonce),
    .cmd_ad(cmd_ad), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_timeout(rsp_timeout), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so), .data_so(data_so),
    .start_so(start_so), .decrypt_so(decrypt_so), .out_si(out_si),
    .tag_si(tag_si), .ready_si(ready_si)
  );

  ascon_serial_host #(.AD_W(64), .DATA_W(64), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t),
    .cmd_decrypt(cmd_decrypt), .cmd_key(cmd_key), .cmd_nonce(cmd_nonce),
    .cmd_ad(cmd_ad), .cmd_data(cmd_data), .rsp_valid(rsp_valid_t),
    .rsp_timeout(rsp_timeout_t), .rsp_data(rsp_data_t), .rsp_tag(rsp_tag_t),
    .key_so(key_so_t), .nonce_so(nonce_so_t), .ad_so(ad_so_t), .data_so(data_so_t),
    .start_so(start_so_t), .decrypt_so(decrypt_so_t), .out_si(1'b0),
    .tag_si(1'b0), .ready_si(1'b0)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in LOAD cycle i=0; collects 128 cycles of pins and ends in the START cycle.
  task automatic load_phase(input logic [127:0] k, input logic [127:0] n,
                            input logic [63:0] a, input logic [63:0] d, input logic dec);
    logic [127:0] gk, gn, ga, gd;
    logic         st, dec_bad;
    st = 1'b0;
    dec_bad = 1'b0;
    for (int i = 0; i < 128; i++) begin
      gk[127-i] = key_so;
      gn[127-i] = nonce_so;
      ga[127-i] = ad_so;
      gd[127-i] = data_so;
      st = st | start_so;
      if (decrypt_so !== dec) dec_bad = 1'b1;
      tick();
    end
    chk128("key_stream", gk, k);
    chk128("nonce_stream", gn, n);
    chk128("ad_stream", ga, {a, 64'd0});
    chk128("data_stream", gd, {d, 64'd0});
    chk1("start_low_in_load", st, 1'b0);
    chk1("decrypt_in_load_bad", dec_bad, 1'b0);
    chk1("start_at_129", start_so, 1'b1);
    chk1("key_idle_at_start", key_so, 1'b0);
  endtask

  // Called in the cycle ready rises; streams bit k in capture cycle k and ends in the DONE cycle.
  task automatic stream(input logic [63:0] o, input logic [127:0] t);
    vcount = 0;
    for (int k = 0; k < 128; k++) begin
      ready_si = 1'b1;
      out_si   = (k < 64) ? o[63-k] : 1'b1;
      tag_si   = t[127-k];
      if (rsp_valid) vcount++;
      tick();
    end
    out_si = 1'b0;
    tag_si = 1'b0;
  endtask

  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NON1 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [63:0]  AD1  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0]  DAT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  OUT1 = 64'hA5C30F9612345678;
  localparam logic [127:0] TAG1 = 128'h5A69F00DDEADBEEF0123456789ABCDEF;
  localparam logic [127:0] KEY2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] NON2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [63:0]  AD2  = 64'h8000000000000001;
  localparam logic [63:0]  DAT2 = 64'hFEDCBA9876543210;
  localparam logic [63:0]  OUT2 = 64'h3C3C0000FFFF1234;
  localparam logic [127:0] TAG2 = 128'hC0FFEE00112233445566778899AABBCC;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid_t = 1'b0; cmd_decrypt = 1'b0;
    cmd_key = '0; cmd_nonce = '0; cmd_ad = '0; cmd_data = '0;
    out_si = 1'b0; tag_si = 1'b0; ready_si = 1'b0;

    // Reset held 3 cycles.
    repeat (3) tick();
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk64("rst_pins", {56'd0, rsp_valid, rsp_timeout, key_so, nonce_so, ad_so, data_so, start_so, decrypt_so}, 64'd0);
    chk64("rst_rsp_data", rsp_data, 64'd0);
    chk128("rst_rsp_tag", rsp_tag, 128'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of LOAD, at i=40.
    cmd_key = '1; cmd_nonce = '1; cmd_ad = '1; cmd_data = '1; cmd_decrypt = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (40) tick();
    chk1("mid_load_key", key_so, 1'b1);
    rst = 1'b1;
    tick();
    chk1("abort_cmd_ready", cmd_ready, 1'b1);
    chk1("abort_key_so", key_so, 1'b0);
    chk1("abort_decrypt_so", decrypt_so, 1'b0);
    rst = 1'b0;
    vcount = 0;
    repeat (8) begin
      if (rsp_valid) vcount++;
      tick();
    end
    chk64("abort_no_rsp", 64'(vcount), 64'd0);

    // Timeout on the TIMEOUT=16 instance: LOAD 1..128, START 129, WAIT 130..145, DONE 146.
    cmd_decrypt = 1'b0;
    cmd_valid_t = 1'b1;
    tick();
    cmd_valid_t = 1'b0;
    first = -1;
    vcount = 0;
    for (int c = 1; c <= 300; c++) begin
      if (rsp_valid_t) begin
        vcount++;
        if (first < 0) first = c;
      end
      tick();
    end
    chk64("to_rsp_cycle", 64'(first), 64'd146);
    chk64("to_rsp_count", 64'(vcount), 64'd1);
    chk1("to_rsp_timeout", rsp_timeout_t, 1'b1);
    chk64("to_rsp_data", rsp_data_t, 64'd0);
    chk128("to_rsp_tag", rsp_tag_t, 128'd0);

    // Encrypt: load, start, ready rises 20 cycles after start, capture.
    cmd_key = KEY1; cmd_nonce = NON1; cmd_ad = AD1; cmd_data = DAT1; cmd_decrypt = 1'b0;
    cmd_valid = 1'b1;
    chk1("enc_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk1("enc_busy", cmd_ready, 1'b0);
    load_phase(KEY1, NON1, AD1, DAT1, 1'b0);
    vcount = 0;
    repeat (20) begin
      if (rsp_valid) vcount++;
      tick();
    end
    chk64("enc_no_early_rsp", 64'(vcount), 64'd0);
    stream(OUT1, TAG1);
    chk64("enc_rsp_during_capture", 64'(vcount), 64'd0);
    chk1("enc_rsp_valid", rsp_valid, 1'b1);
    chk1("enc_rsp_timeout", rsp_timeout, 1'b0);
    chk64("enc_rsp_data", rsp_data, OUT1);
    chk128("enc_rsp_tag", rsp_tag, TAG1);
    chk1("enc_decrypt_so", decrypt_so, 1'b0);

    // Back-to-back decrypt, ready still held high from the previous job.
    cmd_key = KEY2; cmd_nonce = NON2; cmd_ad = AD2; cmd_data = DAT2; cmd_decrypt = 1'b1;
    cmd_valid = 1'b1;
    tick();
    chk1("b2b_rsp_one_cycle", rsp_valid, 1'b0);
    chk1("b2b_cmd_ready", cmd_ready, 1'b1);
    chk64("b2b_rsp_hold", rsp_data, OUT1);
    tick();
    cmd_valid = 1'b0;
    chk1("b2b_accepted", cmd_ready, 1'b0);
    load_phase(KEY2, NON2, AD2, DAT2, 1'b1);
    out_si = 1'b1; tag_si = 1'b1;
    vcount = 0;
    repeat (10) begin
      if (rsp_valid) vcount++;
      tick();
    end
    ready_si = 1'b0;
    repeat (3) begin
      if (rsp_valid) vcount++;
      tick();
    end
    chk64("held_no_capture", 64'(vcount), 64'd0);
    stream(OUT2, TAG2);
    chk64("dec_rsp_during_capture", 64'(vcount), 64'd0);
    chk1("dec_rsp_valid", rsp_valid, 1'b1);
    chk64("dec_rsp_data", rsp_data, OUT2);
    chk128("dec_rsp_tag", rsp_tag, TAG2);
    chk1("dec_decrypt_in_done", decrypt_so, 1'b1);
    tick();
    chk1("dec_decrypt_cleared", decrypt_so, 1'b0);
    chk1("dec_idle_ready", cmd_ready, 1'b1);
    chk1("dec_rsp_cleared", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
